// File: rtl/opti_iir_pkg.sv
// rtl/opti_iir_pkg.sv - shared constants, FSM encoding and arithmetic helpers for opti_iir_mc
//
// Contents:
//   IDX_B0..IDX_A2  position of each coefficient inside a section's 5-entry group
//   NUM_COEF        coefficients per section
//   state_t         FSM encoding (IDLE, CALC, OUT)
//   round_shift     round-half-up arithmetic right shift by frac_w
//   sat_clamp       clamp to the signed range of a data_w-bit value
// Both helpers work on a 64-bit sign-extended accumulator, so any ACC_W up to 64 fits.

package opti_iir_pkg;

    localparam int IDX_B0   = 0;
    localparam int IDX_B1   = 1;
    localparam int IDX_B2   = 2;
    localparam int IDX_A1   = 3;
    localparam int IDX_A2   = 4;
    localparam int NUM_COEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                       input int frac_w);
        logic signed [63:0] half;
        half = 64'sd1 <<< (frac_w - 1);
        return (acc + half) >>> frac_w;
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/opti_biquad_mac.sv
// rtl/opti_biquad_mac.sv - combinational biquad multiply-accumulate with rounding and saturation
//
// Ports:
//   x, x1, x2   current input and the two delayed inputs of the section
//   y1, y2      the two delayed outputs of the section
//   b0..a2      section coefficients, signed Q(DATA_W-FRAC_W).FRAC_W
//   y           sat(round((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >> FRAC_W))
//   sat         high when y was clipped

module opti_biquad_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] y1,
    input  logic [DATA_W-1:0] y2,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] y,
    output logic              sat
);
    import opti_iir_pkg::*;

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
    logic signed [ACC_W-1:0]  acc;
    logic signed [63:0]       rnd;
    logic signed [63:0]       clamped;

    always_comb begin
        p_b0    = PROD_W'($signed(b0)) * PROD_W'($signed(x));
        p_b1    = PROD_W'($signed(b1)) * PROD_W'($signed(x1));
        p_b2    = PROD_W'($signed(b2)) * PROD_W'($signed(x2));
        p_a1    = PROD_W'($signed(a1)) * PROD_W'($signed(y1));
        p_a2    = PROD_W'($signed(a2)) * PROD_W'($signed(y2));
        acc     = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2) - ACC_W'(p_a1) - ACC_W'(p_a2);
        rnd     = round_shift(64'(acc), FRAC_W);
        clamped = sat_clamp(rnd, DATA_W);
        y       = clamped[DATA_W-1:0];
        sat     = (clamped != rnd);
    end

endmodule

// File: rtl/opti_iir_mc.sv
// rtl/opti_iir_mc.sv - multi-channel biquad cascade time-sharing one MAC across sections and channels
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_data/in_ch/in_valid/in_ready       sample input handshake (in_ch >= NUM_CH is accepted and dropped)
//   out_data/out_ch/out_valid/out_ready   filtered sample output handshake
//   coef_we/coef_addr/coef_wdata  coefficient write, addr = sec*5 + {b0,b1,b2,a1,a2}
//   coef_busy                     high outside IDLE; writes ignored while high
//   sat_cnt                       only with OPTI_IIR_SAT_CNT_EN: saturating count of clipped section results
// Optional feature macro: OPTI_IIR_SAT_CNT_EN

module opti_iir_mc #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 14,
    parameter int NUM_SEC = 5,
    parameter int NUM_CH  = 4,
    parameter int ACC_W   = 2 * DATA_W + 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CA_W   = $clog2(NUM_SEC * 5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              coef_we,
    input  logic [CA_W-1:0]   coef_addr,
    input  logic [DATA_W-1:0] coef_wdata,
    output logic              coef_busy
`ifdef OPTI_IIR_SAT_CNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);
    import opti_iir_pkg::*;

    localparam int SEC_W = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

    state_t state, state_nx;

    logic                rdy_q;     // holds in_ready low for the first cycle out of reset
    logic [SEC_W-1:0]    sec_cnt;
    logic [CH_W-1:0]     cur_ch;
    logic [DATA_W-1:0]   cur_x;     // sample for sec 0, then previous section's result
    logic [DATA_W-1:0]   out_q;
    logic [CH_W-1:0]     out_ch_q;

    logic [DATA_W-1:0]   x1_m [NUM_CH][NUM_SEC];
    logic [DATA_W-1:0]   x2_m [NUM_CH][NUM_SEC];
    logic [DATA_W-1:0]   y1_m [NUM_CH][NUM_SEC];
    logic [DATA_W-1:0]   y2_m [NUM_CH][NUM_SEC];
    logic [DATA_W-1:0]   coef [NUM_SEC][NUM_COEF];

    logic                ch_ok;
    logic                take;
    logic                last_sec;
    logic [DATA_W-1:0]   y_mac;
    logic                sat_mac;

    assign ch_ok    = int'(in_ch) < NUM_CH;
    assign take     = (state == IDLE) && rdy_q && in_valid;
    assign last_sec = (sec_cnt == SEC_W'(NUM_SEC - 1));
    assign out_data = out_q;
    assign out_ch   = out_ch_q;

    opti_biquad_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .x   (cur_x),
        .x1  (x1_m[cur_ch][sec_cnt]),
        .x2  (x2_m[cur_ch][sec_cnt]),
        .y1  (y1_m[cur_ch][sec_cnt]),
        .y2  (y2_m[cur_ch][sec_cnt]),
        .b0  (coef[sec_cnt][IDX_B0]),
        .b1  (coef[sec_cnt][IDX_B1]),
        .b2  (coef[sec_cnt][IDX_B2]),
        .a1  (coef[sec_cnt][IDX_A1]),
        .a2  (coef[sec_cnt][IDX_A2]),
        .y   (y_mac),
        .sat (sat_mac)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        coef_busy = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready  = rdy_q;
                coef_busy = 1'b0;
                if (take && ch_ok) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (last_sec) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            sec_cnt  <= '0;
            cur_ch   <= '0;
            cur_x    <= '0;
            out_q    <= '0;
            out_ch_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < NUM_SEC; s++) begin
                    x1_m[c][s] <= '0;
                    x2_m[c][s] <= '0;
                    y1_m[c][s] <= '0;
                    y2_m[c][s] <= '0;
                end
            end
            for (int s = 0; s < NUM_SEC; s++) begin
                for (int k = 0; k < NUM_COEF; k++) begin
                    coef[s][k] <= (k == IDX_B0) ? DATA_W'(1 << FRAC_W) : '0;
                end
            end
        end else begin
            rdy_q <= 1'b1;
            // Writes land on the same edge as a transfer, so that sample sees the new value.
            if (coef_we && (state == IDLE)) begin
                for (int s = 0; s < NUM_SEC; s++) begin
                    for (int k = 0; k < NUM_COEF; k++) begin
                        if (coef_addr == CA_W'(s * NUM_COEF + k)) begin
                            coef[s][k] <= coef_wdata;
                        end
                    end
                end
            end
            if (take && ch_ok) begin
                cur_x   <= in_data;
                cur_ch  <= in_ch;
                sec_cnt <= '0;
            end
            if (state == CALC) begin
                x2_m[cur_ch][sec_cnt] <= x1_m[cur_ch][sec_cnt];
                x1_m[cur_ch][sec_cnt] <= cur_x;
                y2_m[cur_ch][sec_cnt] <= y1_m[cur_ch][sec_cnt];
                y1_m[cur_ch][sec_cnt] <= y_mac;
                cur_x                 <= y_mac;
                sec_cnt               <= sec_cnt + 1'b1;
                if (last_sec) begin
                    out_q    <= y_mac;
                    out_ch_q <= cur_ch;
                    sec_cnt  <= '0;
                end
            end
        end
    end

`ifdef OPTI_IIR_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if ((state == CALC) && sat_mac && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_mac;
`endif

endmodule

// File: tb/tb_opti_iir_mc.sv
// tb/tb_opti_iir_mc.sv - directed self-checking bench for opti_iir_mc (default parameters)

module tb_opti_iir_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_ch = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        coef_busy;
`ifdef OPTI_IIR_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int lat    = 0;
    logic [15:0] imp_exp [4];

    always #5 clk = ~clk;

    opti_iir_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_busy  (coef_busy)
`ifdef OPTI_IIR_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input logic [4:0] a, input logic [15:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] c);
        int n;
        n        = 0;
        in_data  = d;
        in_ch    = c;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat      = 1;
    endtask

    task automatic get_out(input string tag, input logic [15:0] ed, input logic [1:0] ec);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_ch"}, 32'(out_ch), 32'(ec));
        if (out_ready) begin
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        imp_exp[0] = 16'h2000;
        imp_exp[1] = 16'h1000;
        imp_exp[2] = 16'h0800;
        imp_exp[3] = 16'h0400;

        // Reset values
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_coef_busy", 32'(coef_busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef OPTI_IIR_SAT_CNT_EN
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Pass-through defaults with latency
        send(16'h1000, 2'd0);
        get_out("pt0", 16'h1000, 2'd0);
        chk("pt0_lat", 32'(lat), 32'd6);
        send(16'hC000, 2'd0);
        get_out("pt1", 16'hC000, 2'd0);
        chk("pt1_lat", 32'(lat), 32'd6);

        // Impulse on ch1; b0 written in the same cycle the impulse is accepted
        wcoef(5'd3, 16'hE000);
        chk("ws_ready", 32'(in_ready), 32'd1);
        coef_we    = 1'b1;
        coef_addr  = 5'd0;
        coef_wdata = 16'h2000;
        in_data    = 16'h4000;
        in_ch      = 2'd1;
        in_valid   = 1'b1;
        tick();
        coef_we  = 1'b0;
        in_valid = 1'b0;
        chk("ws_busy", 32'(coef_busy), 32'd1);
        get_out("imp0", imp_exp[0], 2'd1);
        for (int i = 1; i < 4; i++) begin
            send(16'h0000, 2'd1);
            get_out("imp", imp_exp[i], 2'd1);
        end

        // Channel isolation: ch0 impulse interleaved with ch2 zeros
        do_reset();
        wcoef(5'd0, 16'h2000);
        wcoef(5'd3, 16'hE000);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 16'h4000 : 16'h0000, 2'd0);
            get_out("iso_ch0", imp_exp[i], 2'd0);
            send(16'h0000, 2'd2);
            get_out("iso_ch2", 16'h0000, 2'd2);
        end

        // Backpressure on ch3 with a pending sample and an ignored a1 write
        out_ready = 1'b0;
        send(16'h4000, 2'd3);
        get_out("bp", 16'h2000, 2'd3);
        in_valid   = 1'b1;
        in_data    = 16'h0000;
        in_ch      = 2'd3;
        coef_we    = 1'b1;
        coef_addr  = 5'd3;
        coef_wdata = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            coef_we = 1'b0;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h2000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(coef_busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", 32'(out_valid), 32'd0);
        send(16'h0000, 2'd3);
        get_out("bp_next", 16'h1000, 2'd3);

        // Saturation, positive and negative
        do_reset();
        for (int s = 0; s < 5; s++) begin
            wcoef(5'(s * 5), 16'h7FFF);
        end
        send(16'h7FFF, 2'd0);
        get_out("sat_pos", 16'h7FFF, 2'd0);
`ifdef OPTI_IIR_SAT_CNT_EN
        chk("sat_cnt_pos", 32'(sat_cnt), 32'd5);
`endif
        send(16'h8000, 2'd0);
        get_out("sat_neg", 16'h8000, 2'd0);
`ifdef OPTI_IIR_SAT_CNT_EN
        chk("sat_cnt_neg", 32'(sat_cnt), 32'd10);
`endif

        // Reset in the third CALC cycle
        send(16'h1000, 2'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(coef_busy), 32'd0);
        tick();
        chk("mid_rst_valid_next", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        send(16'h1000, 2'd0);
        get_out("post_rst", 16'h1000, 2'd0);
        chk("post_rst_lat", 32'(lat), 32'd6);
`ifdef OPTI_IIR_SAT_CNT_EN
        chk("post_rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
